// File: rtl/sound_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sound_latch_ctrl
// Brief    : 68K->Z80 sound command latch, Z80 ROM bank register and
//            periodic Z80 maskable-interrupt generator.
// Revision : 1.0 - initial release
// ============================================================================
module sound_latch_ctrl #(
    parameter logic [15:0] IRQ_PERIOD = 16'd16384,
    parameter int          BANK_BITS  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    z80_clk_en,
    input  logic                    m68k_latch_cs,
    input  logic                    m68k_lds_n,
    input  logic [15:0]             m68k_dout,
    input  logic                    z80_latch_cs,
    input  logic                    z80_latch_clr_cs,
    input  logic                    z80_bank_set_cs,
    input  logic [7:0]              z80_dout,
    input  logic [15:0]             z80_addr,
    input  logic                    M1_n,
    input  logic                    IORQ_n,
    output logic [7:0]              sound_latch,
    output logic                    latch_pending,
    output logic                    z80_irq_n,
    output logic [BANK_BITS-1:0]    z80_bank,
    output logic [14+BANK_BITS-1:0] z80_banked_addr
);

    localparam logic [15:0] c_irq_last = IRQ_PERIOD - 16'd1;
    localparam logic [0:0]  c_st_idle  = 1'b0;
    localparam logic [0:0]  c_st_req   = 1'b1;

    logic                 r_wr_term_d;
    logic                 r_clr_d;
    logic                 r_bank_d;
    logic [7:0]           r_latch;
    logic                 r_pending;
    logic [BANK_BITS-1:0] r_bank;
    logic [15:0]          r_irq_cnt;
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;

    logic w_wr_term;
    logic w_wr_evt;
    logic w_clr_evt;
    logic w_bank_evt;
    logic w_tc;
    logic w_ack;
    logic w_unused;

    assign w_wr_term  = m68k_latch_cs & ~m68k_lds_n;
    assign w_wr_evt   = w_wr_term & ~r_wr_term_d;
    assign w_clr_evt  = z80_latch_clr_cs & ~r_clr_d;
    assign w_bank_evt = z80_bank_set_cs & ~r_bank_d;
    assign w_tc       = z80_clk_en && (r_irq_cnt == c_irq_last);
    assign w_ack      = ~M1_n & ~IORQ_n;

    // Reads of the latch have no side effects; these inputs only feed this sink.
    assign w_unused = ^{m68k_dout[15:8], z80_dout, z80_addr[15:14], z80_latch_cs};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_term_d <= 1'b0;
            r_clr_d     <= 1'b0;
            r_bank_d    <= 1'b0;
            r_latch     <= 8'h00;
            r_pending   <= 1'b0;
            r_bank      <= '0;
            r_irq_cnt   <= 16'd0;
        end else begin
            r_wr_term_d <= w_wr_term;
            r_clr_d     <= z80_latch_clr_cs;
            r_bank_d    <= z80_bank_set_cs;
            // A coincident 68K write takes priority over the Z80 clear.
            if (w_wr_evt) begin
                r_latch   <= m68k_dout[7:0];
                r_pending <= 1'b1;
            end else if (w_clr_evt) begin
                r_latch   <= 8'h00;
                r_pending <= 1'b0;
            end
            if (w_bank_evt) begin
                r_bank <= z80_dout[BANK_BITS-1:0];
            end
            if (z80_clk_en) begin
                r_irq_cnt <= w_tc ? 16'd0 : r_irq_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Terminal count beats acknowledge; repeated terminal counts simply hold REQ.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_tc)           w_state_nxt = c_st_req;
            c_st_req:  if (w_ack && !w_tc) w_state_nxt = c_st_idle;
            default:                       w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        z80_irq_n = 1'b1;
        if (r_state == c_st_req) begin
            z80_irq_n = 1'b0;
        end
    end

    assign sound_latch     = r_latch;
    assign latch_pending   = r_pending;
    assign z80_bank        = r_bank;
    assign z80_banked_addr = {r_bank, z80_addr[13:0]};

endmodule
`default_nettype wire

// File: tb/tb_sound_latch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_latch_ctrl
// Brief    : Directed self-checking bench for sound_latch_ctrl (IRQ_PERIOD=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_latch_ctrl;

    localparam int BB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          z80_clk_en;
    logic          m68k_latch_cs;
    logic          m68k_lds_n;
    logic [15:0]   m68k_dout;
    logic          z80_latch_cs;
    logic          z80_latch_clr_cs;
    logic          z80_bank_set_cs;
    logic [7:0]    z80_dout;
    logic [15:0]   z80_addr;
    logic          M1_n;
    logic          IORQ_n;
    logic [7:0]    sound_latch;
    logic          latch_pending;
    logic          z80_irq_n;
    logic [BB-1:0] z80_bank;
    logic [13+BB:0] z80_banked_addr;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    sound_latch_ctrl #(.IRQ_PERIOD(16'd4), .BANK_BITS(BB)) dut (
        .clk(clk), .reset(reset), .z80_clk_en(z80_clk_en),
        .m68k_latch_cs(m68k_latch_cs), .m68k_lds_n(m68k_lds_n), .m68k_dout(m68k_dout),
        .z80_latch_cs(z80_latch_cs), .z80_latch_clr_cs(z80_latch_clr_cs),
        .z80_bank_set_cs(z80_bank_set_cs), .z80_dout(z80_dout), .z80_addr(z80_addr),
        .M1_n(M1_n), .IORQ_n(IORQ_n),
        .sound_latch(sound_latch), .latch_pending(latch_pending), .z80_irq_n(z80_irq_n),
        .z80_bank(z80_bank), .z80_banked_addr(z80_banked_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic push_latch(input string tag, input logic [7:0] d, input logic p);
        push({tag, "_latch"}, {24'd0, d});
        push({tag, "_pend"}, {31'd0, p});
    endtask

    task automatic check_latch();
        pop_check({24'd0, sound_latch});
        pop_check({31'd0, latch_pending});
    endtask

    task automatic push_irq(input string tag, input logic v);
        push(tag, {31'd0, v});
    endtask

    task automatic check_irq();
        pop_check({31'd0, z80_irq_n});
    endtask

    // One enable pulse followed by an idle cycle.
    task automatic en_tick();
        z80_clk_en = 1'b1;
        tick();
        z80_clk_en = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; z80_clk_en = 1'b0;
        m68k_latch_cs = 1'b0; m68k_lds_n = 1'b1; m68k_dout = 16'h0;
        z80_latch_cs = 1'b0; z80_latch_clr_cs = 1'b0; z80_bank_set_cs = 1'b0;
        z80_dout = 8'h0; z80_addr = 16'h0; M1_n = 1'b1; IORQ_n = 1'b1;
        tick(); tick();

        // Reset state
        push_latch("rst", 8'h00, 1'b0);
        push_irq("rst_irq", 1'b1);
        push("rst_bank", 32'h0);
        check_latch(); check_irq(); pop_check({27'd0, z80_bank});
        reset = 1'b0;
        tick();

        // Write with LDS# high is ignored
        m68k_latch_cs = 1'b1; m68k_lds_n = 1'b1; m68k_dout = 16'h00FF;
        tick(); tick();
        push_latch("lds_hi", 8'h00, 1'b0);
        check_latch();
        m68k_latch_cs = 1'b0; tick();

        // Held strobe yields exactly one write; later data changes are not taken
        m68k_latch_cs = 1'b1; m68k_lds_n = 1'b0; m68k_dout = 16'h12A5;
        for (int i = 0; i < 4; i++) begin
            tick();
            push_latch("hold", 8'hA5, 1'b1);
            check_latch();
            m68k_dout = 16'h005A;
        end
        m68k_latch_cs = 1'b0; tick();

        // Write 3C then clear
        m68k_latch_cs = 1'b1; m68k_dout = 16'h003C; tick();
        push_latch("wr3c", 8'h3C, 1'b1); check_latch();
        m68k_latch_cs = 1'b0; tick();
        z80_latch_clr_cs = 1'b1; tick();
        push_latch("clr", 8'h00, 1'b0); check_latch();
        z80_latch_clr_cs = 1'b0; tick();

        // Simultaneous write and clear: write wins
        m68k_latch_cs = 1'b1; m68k_dout = 16'h0077; z80_latch_clr_cs = 1'b1; tick();
        push_latch("wr_clr", 8'h77, 1'b1); check_latch();
        m68k_latch_cs = 1'b0; z80_latch_clr_cs = 1'b0; tick();

        // Z80 read leaves the latch alone
        z80_latch_cs = 1'b1; tick(); tick();
        push_latch("rd", 8'h77, 1'b1); check_latch();
        z80_latch_cs = 1'b0; tick();

        // Bank register and banked address
        z80_dout = 8'hF3; z80_bank_set_cs = 1'b1; tick();
        z80_addr = 16'hC123; #1;
        push("bank", 32'h13); push("baddr", 32'h4C123);
        pop_check({27'd0, z80_bank}); pop_check({13'd0, z80_banked_addr});
        z80_dout = 8'h05; tick(); tick();
        push("bank_lvl", 32'h13); pop_check({27'd0, z80_bank});
        z80_bank_set_cs = 1'b0; tick();

        // IRQ generation from a fresh counter
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            en_tick();
            push_irq($sformatf("irq_en%0d", i), (i < 4) ? 1'b1 : 1'b0);
            check_irq();
        end
        M1_n = 1'b0; IORQ_n = 1'b0; tick(); M1_n = 1'b1; IORQ_n = 1'b1;
        push_irq("ack", 1'b1); check_irq();
        tick();

        // No acknowledge: falls again and stays low across further terminal counts
        for (int i = 1; i <= 12; i++) begin
            en_tick();
            push_irq($sformatf("noack_en%0d", i), (i < 4) ? 1'b1 : 1'b0);
            check_irq();
        end

        // Acknowledge coincident with terminal count: assert wins
        en_tick(); en_tick(); en_tick();
        z80_clk_en = 1'b1; M1_n = 1'b0; IORQ_n = 1'b0; tick();
        z80_clk_en = 1'b0; M1_n = 1'b1; IORQ_n = 1'b1;
        push_irq("ack_tc", 1'b0); check_irq();
        tick();
        M1_n = 1'b0; IORQ_n = 1'b0; tick(); M1_n = 1'b1; IORQ_n = 1'b1;
        push_irq("ack2", 1'b1); check_irq();

        // Mid-operation reset with IRQ low, bank 1F, latch pending
        z80_dout = 8'h1F; z80_bank_set_cs = 1'b1; tick(); z80_bank_set_cs = 1'b0;
        m68k_latch_cs = 1'b1; m68k_dout = 16'h0042; tick(); m68k_latch_cs = 1'b0;
        en_tick(); en_tick(); en_tick(); en_tick();
        push_irq("pre_rst_irq", 1'b0); check_irq();
        push("pre_rst_bank", 32'h1F); pop_check({27'd0, z80_bank});
        push_latch("pre_rst", 8'h42, 1'b1); check_latch();
        reset = 1'b1; tick();
        push_irq("mid_rst_irq", 1'b1); check_irq();
        push("mid_rst_bank", 32'h0); pop_check({27'd0, z80_bank});
        push_latch("mid_rst", 8'h00, 1'b0); check_latch();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            en_tick();
            push_irq($sformatf("post_rst_en%0d", i), (i < 4) ? 1'b1 : 1'b0);
            check_irq();
        end

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
